// File: rtl/gin_mcast.sv
// Global input network: scan-programmed row/col IDs, packet FIFO, tag-matched multicast to the PE array.
// Latency: a packet accepted into an empty FIFO strobes its PEs one edge later; one packet per cycle.
// Backpressure: gin_ready drops when the FIFO is full or programming; the head waits until all targets are ready.
module gin_mcast #(
   parameter int BITWIDTH   = 16,
   parameter int TAG_LENGTH = 4,
   parameter int X_BUS_SIZE = 4,
   parameter int Y_BUS_SIZE = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                       clk,
   input  logic                                       rstb,
   input  logic                                       program_en,
   input  logic [TAG_LENGTH-1:0]                      scan_tag_in,
   output logic [TAG_LENGTH-1:0]                      scan_tag_out,
   input  logic                                       gin_enable,
   output logic                                       gin_ready,
   input  logic [2*TAG_LENGTH+BITWIDTH-1:0]           data_packet,
   output logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_enable,
   input  logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_ready,
   output logic [BITWIDTH*X_BUS_SIZE*Y_BUS_SIZE-1:0]  pe_value,
   output logic [$clog2(FIFO_DEPTH):0]                fifo_count,
   output logic [7:0]                                 drop_count
);
   localparam int NUM_PE   = X_BUS_SIZE * Y_BUS_SIZE;
   localparam int PKT_W    = 2 * TAG_LENGTH + BITWIDTH;
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int NUM_TAGS = Y_BUS_SIZE + NUM_PE;
   localparam logic [TAG_LENGTH-1:0] WILDCARD   = '1;
   localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]      ONE_COUNT  = CNT_W'(1);

   typedef enum logic [1:0] {PROG_IDLE, ISSUE, STALL} state_t;

   state_t                state;
   logic [TAG_LENGTH-1:0] tag_chain [NUM_TAGS];
   logic [PKT_W-1:0]      fifo_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [TAG_LENGTH-1:0] head_row;
   logic [TAG_LENGTH-1:0] head_col;
   logic [BITWIDTH-1:0]   head_data;
   logic [NUM_PE-1:0]     mask;
   logic                  has_head;
   logic                  targets_ready;
   logic                  deliver;
   logic                  drop;
   logic                  pop;
   logic                  push;
   logic                  more_left;

   // Scan chain: entries 0..Y-1 are row IDs, entries Y.. are per-PE column IDs; shifts toward entry 0.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int k = 0; k < NUM_TAGS; k++) tag_chain[k] <= '0;
      end else if (program_en) begin
         for (int k = 0; k < NUM_TAGS - 1; k++) tag_chain[k] <= tag_chain[k+1];
         tag_chain[NUM_TAGS-1] <= scan_tag_in;
      end
   end

   assign scan_tag_out = tag_chain[0];

   // Readiness uses the pre-pop count, so a full FIFO never accepts even while draining.
   assign gin_ready = rstb & ~program_en & (fifo_count < FULL_COUNT);
   assign push      = gin_enable & gin_ready;

   assign {head_row, head_col, head_data} = fifo_mem[rd_ptr];

   // Target mask for the head packet; an all-ones tag matches every row or column.
   always_comb begin
      mask = '0;
      for (int r = 0; r < Y_BUS_SIZE; r++) begin
         for (int c = 0; c < X_BUS_SIZE; c++) begin
            mask[r*X_BUS_SIZE+c] =
               ((head_row == tag_chain[r]) || (head_row == WILDCARD)) &&
               ((head_col == tag_chain[Y_BUS_SIZE + r*X_BUS_SIZE + c]) || (head_col == WILDCARD));
         end
      end
   end

   // ISSUE/STALL always hold a queued head; IDLE checks the FIFO so a lone packet issues the very next edge.
   assign has_head      = (state != PROG_IDLE) || (fifo_count != '0);
   assign targets_ready = ((mask & ~pe_ready) == '0);
   assign deliver       = !program_en && has_head && (mask != '0) && targets_ready;
   assign drop          = !program_en && has_head && (mask == '0);
   assign pop           = deliver | drop;
   assign more_left     = (fifo_count != ONE_COUNT) || push;

   // Queue pointers and occupancy; power-of-two depth lets pointers wrap on their own.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Packet storage is data-only and needs no reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= data_packet;
   end

   // Issue FSM: deliver, drop or stall the head; registered one-cycle strobes and held per-PE data.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= PROG_IDLE;
         pe_enable  <= '0;
         pe_value   <= '0;
         drop_count <= '0;
      end else begin
         pe_enable <= '0;
         if (program_en || !has_head) begin
            state <= PROG_IDLE;
         end else if (drop) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            state <= more_left ? ISSUE : PROG_IDLE;
         end else if (deliver) begin
            pe_enable <= mask;
            for (int p = 0; p < NUM_PE; p++) begin
               if (mask[p]) pe_value[BITWIDTH*p +: BITWIDTH] <= head_data;
            end
            state <= more_left ? ISSUE : PROG_IDLE;
         end else begin
            state <= STALL;
         end
      end
   end
endmodule

// File: tb/tb_gin_mcast.sv
// Directed bench for gin_mcast: scan chain, unicast, wildcard, stall/order, drop, async reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every packet send is bounded and reports a timeout as a failure.
module tb_gin_mcast;
   localparam int BW  = 16;
   localparam int TL  = 4;
   localparam int NPE = 16;
   localparam int PW  = 2*TL + BW;

   logic              clk = 1'b0;
   logic              rstb;
   logic              program_en;
   logic [TL-1:0]     scan_tag_in;
   logic [TL-1:0]     scan_tag_out;
   logic              gin_enable;
   logic              gin_ready;
   logic [PW-1:0]     data_packet;
   logic [NPE-1:0]    pe_enable;
   logic [NPE-1:0]    pe_ready;
   logic [BW*NPE-1:0] pe_value;
   logic [2:0]        fifo_count;
   logic [7:0]        drop_count;

   int tests = 0;
   int fails = 0;

   gin_mcast #(.BITWIDTH(16), .TAG_LENGTH(4), .X_BUS_SIZE(4), .Y_BUS_SIZE(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstb(rstb), .program_en(program_en), .scan_tag_in(scan_tag_in),
      .scan_tag_out(scan_tag_out), .gin_enable(gin_enable), .gin_ready(gin_ready),
      .data_packet(data_packet), .pe_enable(pe_enable), .pe_ready(pe_ready),
      .pe_value(pe_value), .fifo_count(fifo_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] slice(input int p);
      return pe_value[BW*p +: BW];
   endfunction

   task automatic send(input logic [3:0] row, input logic [3:0] col, input logic [15:0] dat);
      int n;
      n = 0;
      data_packet = {row, col, dat};
      gin_enable  = 1'b1;
      while (!gin_ready && n < 50) begin
         tick();
         n++;
      end
      if (!gin_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: gin_ready=%b want 1", gin_ready);
      end
      tick();
      gin_enable = 1'b0;
   endtask

   task automatic test_reset();
      rstb = 1'b0; program_en = 1'b0; scan_tag_in = '0; gin_enable = 1'b0;
      data_packet = '0; pe_ready = '1;
      #12;
      tests++; if (gin_ready !== 1'b0) begin fails++; $display("FAIL rst_gin_ready: got %b want 0", gin_ready); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL rst_pe_enable: got %h want 0", pe_enable); end
      tests++; if (pe_value !== '0) begin fails++; $display("FAIL rst_pe_value: got %h want 0", pe_value); end
      tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
      tests++; if (scan_tag_out !== 4'd0) begin fails++; $display("FAIL rst_scan_out: got %0d want 0", scan_tag_out); end
      @(negedge clk);
      rstb = 1'b1;
      tick();
      tests++; if (gin_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", gin_ready); end
   endtask

   // Rows get IDs 0..3, PE p gets column ID p%4; the second pass replays the first.
   task automatic test_scan();
      logic [3:0] exp;
      program_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         scan_tag_in = 4'(i % 4);
         tick();
      end
      tests++; if (gin_ready !== 1'b0) begin fails++; $display("FAIL prog_ready: got %b want 0", gin_ready); end
      for (int i = 0; i < 20; i++) begin
         exp = 4'(i % 4);
         tests++;
         if (scan_tag_out !== exp) begin
            fails++; $display("FAIL scan_replay[%0d]: got %0d want %0d", i, scan_tag_out, exp);
         end
         scan_tag_in = exp;
         tick();
      end
      program_en = 1'b0;
      tick();
   endtask

   task automatic test_unicast();
      send(4'd1, 4'd2, 16'hABCD);
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL uni_early: got %h want 0", pe_enable); end
      tick();
      tests++; if (pe_enable !== 16'h0040) begin fails++; $display("FAIL uni_enable: got %h want 0040", pe_enable); end
      tests++; if (slice(6) !== 16'hABCD) begin fails++; $display("FAIL uni_slice6: got %h want abcd", slice(6)); end
      tests++; if (slice(5) !== 16'h0) begin fails++; $display("FAIL uni_slice5: got %h want 0", slice(5)); end
      tests++; if (slice(0) !== 16'h0) begin fails++; $display("FAIL uni_slice0: got %h want 0", slice(0)); end
      tick();
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL uni_one_cycle: got %h want 0", pe_enable); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL uni_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_wildcard();
      send(4'hF, 4'd0, 16'd7);
      tick();
      tests++; if (pe_enable !== 16'h1111) begin fails++; $display("FAIL wc_enable: got %h want 1111", pe_enable); end
      for (int i = 0; i < 16; i += 4) begin
         tests++;
         if (slice(i) !== 16'd7) begin fails++; $display("FAIL wc_slice%0d: got %h want 0007", i, slice(i)); end
      end
      tests++; if (slice(6) !== 16'hABCD) begin fails++; $display("FAIL wc_hold6: got %h want abcd", slice(6)); end
      tick();
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL wc_one_cycle: got %h want 0", pe_enable); end
   endtask

   task automatic test_stall_order();
      pe_ready[6] = 1'b0;
      send(4'd1, 4'd2, 16'h00A1);
      send(4'd0, 4'd0, 16'h00B2);
      send(4'd2, 4'd1, 16'h00C3);
      send(4'd3, 4'd3, 16'h00D4);
      tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL stall_count: got %0d want 4", fifo_count); end
      tests++; if (gin_ready !== 1'b0) begin fails++; $display("FAIL stall_full_ready: got %b want 0", gin_ready); end
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL stall_enable: got %h want 0", pe_enable); end
      data_packet = {4'd2, 4'd2, 16'hEEEE};
      gin_enable  = 1'b1;
      tick();
      tick();
      gin_enable = 1'b0;
      tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_no_accept: got %0d want 4", fifo_count); end
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL stall_hold: got %h want 0", pe_enable); end
      pe_ready[6] = 1'b1;
      tick();
      tests++; if (pe_enable !== 16'h0040) begin fails++; $display("FAIL order_a: got %h want 0040", pe_enable); end
      tests++; if (slice(6) !== 16'h00A1) begin fails++; $display("FAIL order_a_val: got %h want 00a1", slice(6)); end
      tick();
      tests++; if (pe_enable !== 16'h0001) begin fails++; $display("FAIL order_b: got %h want 0001", pe_enable); end
      tests++; if (slice(0) !== 16'h00B2) begin fails++; $display("FAIL order_b_val: got %h want 00b2", slice(0)); end
      tick();
      tests++; if (pe_enable !== 16'h0200) begin fails++; $display("FAIL order_c: got %h want 0200", pe_enable); end
      tests++; if (slice(9) !== 16'h00C3) begin fails++; $display("FAIL order_c_val: got %h want 00c3", slice(9)); end
      tick();
      tests++; if (pe_enable !== 16'h8000) begin fails++; $display("FAIL order_d: got %h want 8000", pe_enable); end
      tests++; if (slice(15) !== 16'h00D4) begin fails++; $display("FAIL order_d_val: got %h want 00d4", slice(15)); end
      tick();
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL drain_enable: got %h want 0", pe_enable); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_drop();
      send(4'd9, 4'd0, 16'h1234);
      tick();
      tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL drop_count: got %0d want 1", drop_count); end
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL drop_enable: got %h want 0", pe_enable); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL drop_pop: got %0d want 0", fifo_count); end
      send(4'd2, 4'd3, 16'h0C0C);
      tick();
      tests++; if (pe_enable !== 16'h0800) begin fails++; $display("FAIL after_drop: got %h want 0800", pe_enable); end
      tests++; if (slice(11) !== 16'h0C0C) begin fails++; $display("FAIL after_drop_val: got %h want 0c0c", slice(11)); end
   endtask

   task automatic test_reset_mid_stall();
      pe_ready[6] = 1'b0;
      send(4'd1, 4'd2, 16'h1111);
      send(4'd1, 4'd2, 16'h2222);
      send(4'd1, 4'd2, 16'h3333);
      tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL pre_rst_count: got %0d want 3", fifo_count); end
      #2;
      rstb = 1'b0;
      #1;
      tests++; if (pe_enable !== 16'h0) begin fails++; $display("FAIL arst_enable: got %h want 0", pe_enable); end
      tests++; if (pe_value !== '0) begin fails++; $display("FAIL arst_value: got %h want 0", pe_value); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
      tests++; if (gin_ready !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b want 0", gin_ready); end
      tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL arst_drop: got %0d want 0", drop_count); end
      pe_ready = '1;
      @(negedge clk);
      rstb = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_scan();
      test_unicast();
      test_wildcard();
      test_stall_order();
      test_drop();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end
endmodule
